// File: rtl/keccak_arb_pkg.sv
// Shared types and width constants for the keccak arbiter slice.
// The optional stall-abort timeout is enabled with KECCAK_ARB_TIMEOUT_EN.
package keccak_arb_pkg;

  localparam int WORD_W   = 32;
  localparam int DIGEST_W = 512;
  localparam int BN_W     = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    FEED = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/keccak_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int             IW  = $clog2(N);
  localparam logic [IW:0]    N_W = (IW+1)'(N);

  logic [IW:0] pos;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + k[IW:0];
      if (pos >= N_W) pos = pos - N_W;
      if (!found && req[pos[IW-1:0]]) begin
        found              = 1'b1;
        gnt[pos[IW-1:0]]   = 1'b1;
        idx                = pos[IW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core between NREQ requesters, one whole message per grant.
// Define KECCAK_ARB_TIMEOUT_EN to abort a grant after STALL_LIMIT idle FEED cycles.
module keccak_arbiter
  import keccak_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*WORD_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*BN_W-1:0]   req_byte_num,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        dig_valid,
  output logic [DIGEST_W-1:0]    digest,
  output logic [NREQ-1:0]        abort,
  output logic                   core_reset,
  output logic [WORD_W-1:0]      core_in,
  output logic                   core_in_ready,
  output logic                   core_is_last,
  output logic [BN_W-1:0]        core_byte_num,
  input  logic                   core_buffer_full,
  input  logic [DIGEST_W-1:0]    core_out,
  input  logic                   core_out_ready
);

  localparam int IW = $clog2(NREQ);

  arb_state_e          state_q, state_d;
  logic [NREQ-1:0]     grant_q;
  logic [IW-1:0]       gidx_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       ptr_next;
  logic [DIGEST_W-1:0] digest_q;
  logic                core_reset_q;

  logic [NREQ-1:0]     pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  logic                sel_valid;
  logic                stall_hit;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Word path: mux the granted slot straight through to the core.
  always_comb begin
    sel_valid     = 1'b0;
    core_is_last  = 1'b0;
    core_in       = '0;
    core_byte_num = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_q == IW'(i)) begin
        sel_valid     = req_valid[i];
        core_is_last  = req_last[i];
        core_in       = req_data[i*WORD_W +: WORD_W];
        core_byte_num = req_byte_num[i*BN_W +: BN_W];
      end
    end
  end

  assign ptr_next = (gidx_q == IW'(NREQ-1)) ? '0 : gidx_q + IW'(1);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    core_in_ready = 1'b0;
    req_ready     = '0;
    dig_valid     = '0;
    case (state_q)
      IDLE: if (pick_any) state_d = CLR;
      CLR:  state_d = FEED;
      FEED: begin
        core_in_ready = sel_valid & ~core_buffer_full;
        req_ready     = grant_q & {NREQ{core_in_ready}};
        if (core_in_ready && core_is_last) state_d = WAIT;
        else if (stall_hit)                state_d = IDLE;
      end
      WAIT: if (core_out_ready) state_d = DONE;
      DONE: begin
        dig_valid = grant_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the digest register is reset because it is visible to requesters as a clean 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      ptr_q        <= '0;
      digest_q     <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      core_reset_q <= (state_d == CLR);
      case (state_q)
        IDLE: if (pick_any) begin
          grant_q <= pick_gnt;
          gidx_q  <= pick_idx;
        end
        FEED: if (stall_hit) begin
          grant_q <= '0;
          ptr_q   <= ptr_next;
        end
        WAIT: if (core_out_ready) digest_q <= core_out;
        DONE: begin
          grant_q <= '0;
          ptr_q   <= ptr_next;
        end
        default: ;
      endcase
    end
  end

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam int CNT_W = (STALL_LIMIT > 255) ? $clog2(STALL_LIMIT + 1) : 8;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [NREQ-1:0]  abort_q;

  // The cycle that would bring the idle count up to STALL_LIMIT triggers the abort.
  assign stall_hit = (state_q == FEED) && !sel_valid &&
                     (stall_cnt_q == CNT_W'(STALL_LIMIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      abort_q     <= '0;
    end else begin
      abort_q <= stall_hit ? grant_q : '0;
      if (state_q != FEED || core_in_ready || stall_hit) stall_cnt_q <= '0;
      else if (!sel_valid)                             stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign abort = abort_q;
`else
  assign stall_hit = 1'b0;
  assign abort     = '0;
`endif

  assign grant      = grant_q;
  assign digest     = digest_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter with a small order-sensitive stand-in for the core.
// Covers the timeout path when KECCAK_ARB_TIMEOUT_EN is defined (STALL_LIMIT=4).
module tb_keccak_arbiter;

  localparam int NREQ = 4;

  logic                clk;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ*2-1:0]   req_byte_num;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     dig_valid;
  logic [511:0]        digest;
  logic [NREQ-1:0]     abort;
  logic                core_reset;
  logic [31:0]         core_in;
  logic                core_in_ready;
  logic                core_is_last;
  logic [1:0]          core_byte_num;
  logic                core_buffer_full;
  logic [511:0]        core_out;
  logic                core_out_ready;

  int tests = 0;
  int fails = 0;

  logic [31:0] msg_w [8];
  int          msg_n;
  logic [1:0]  msg_bn;

  keccak_arbiter #(.NREQ(NREQ), .STALL_LIMIT(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_byte_num     (req_byte_num),
    .req_ready        (req_ready),
    .grant            (grant),
    .dig_valid        (dig_valid),
    .digest           (digest),
    .abort            (abort),
    .core_reset       (core_reset),
    .core_in          (core_in),
    .core_in_ready    (core_in_ready),
    .core_is_last     (core_is_last),
    .core_byte_num    (core_byte_num),
    .core_buffer_full (core_buffer_full),
    .core_out         (core_out),
    .core_out_ready   (core_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in core: rotate-xor accumulator, result ready 3 cycles after the last word.
  logic [31:0] m_acc;
  logic [15:0] m_cnt;
  logic [1:0]  m_bn;
  int          m_delay;
  logic        m_ready;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || core_reset) begin
      m_acc <= '0; m_cnt <= '0; m_bn <= '0; m_delay <= 0; m_ready <= 1'b0;
    end else if (core_in_ready) begin
      m_acc <= {m_acc[26:0], m_acc[31:27]} ^ core_in;
      m_cnt <= m_cnt + 16'd1;
      if (core_is_last) begin
        m_bn    <= core_byte_num;
        m_delay <= 3;
      end
    end else if (m_delay > 0) begin
      m_delay <= m_delay - 1;
      if (m_delay == 1) m_ready <= 1'b1;
    end
  end

  assign core_out       = {448'h0, m_cnt, 14'h0, m_bn, m_acc};
  assign core_out_ready = m_ready;

  function automatic logic [511:0] exp_digest();
    logic [31:0] a;
    a = '0;
    for (int i = 0; i < msg_n; i++) a = {a[26:0], a[31:27]} ^ msg_w[i];
    return {448'h0, 16'(msg_n), 14'h0, msg_bn, a};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int idx, input logic [31:0] w, input logic last, input logic [1:0] bn);
    req_valid[idx]            = 1'b1;
    req_data[idx*32 +: 32]    = w;
    req_last[idx]             = last;
    req_byte_num[idx*2 +: 2]  = bn;
  endtask

  task automatic wait_accept(input int idx);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      #1;
      if (req_ready[idx]) ok = 1'b1;
      @(negedge clk);
    end
    check("word_accept", ok, 1);
  endtask

  task automatic feed(input int idx, input int from, input int to);
    for (int w = from; w <= to; w++) begin
      present(idx, msg_w[w], w == msg_n - 1, (w == msg_n - 1) ? msg_bn : 2'd0);
      wait_accept(idx);
    end
    req_valid[idx] = 1'b0;
  endtask

  task automatic await_grant(input int idx);
    for (int t = 0; t < 10 && grant == '0; t++) @(negedge clk);
    check("grant", grant, 512'(1) << idx);
    @(negedge clk);
  endtask

  task automatic wait_dig(input int idx, input string tag);
    for (int t = 0; t < 64 && dig_valid == '0; t++) @(negedge clk);
    check({tag, "_dig_valid"}, dig_valid, 512'(1) << idx);
    check({tag, "_digest"}, digest, exp_digest());
    @(negedge clk);
    check({tag, "_pulse_end"}, dig_valid, 0);
    check({tag, "_grant_clr"}, grant, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; req_byte_num = '0;
    core_buffer_full = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   hit;
    reset_n = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; req_byte_num = '0;
    core_buffer_full = 1'b0;
    for (int i = 0; i < 8; i++) msg_w[i] = '0;
    msg_n = 0; msg_bn = '0;
    #1 reset_n = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_dig_valid", dig_valid, 0);
    check("rst_abort", abort, 0);
    check("rst_digest", digest, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_core_in_ready", core_in_ready, 0);
    check("rst_req_ready", req_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("core_reset_drop", core_reset, 0);

    // Single requester, "Hello world" in 3 words
    msg_w[0] = 32'h48656C6C; msg_w[1] = 32'h6F20776F; msg_w[2] = 32'h726C6400;
    msg_n = 3; msg_bn = 2'd3;
    present(0, msg_w[0], 1'b0, 2'd0);
    @(negedge clk);
    check("hello_grant", grant, 4'b0001);
    check("hello_clr_reset", core_reset, 1);
    check("hello_clr_ready", req_ready, 0);
    @(negedge clk);
    check("hello_reset_1cyc", core_reset, 0);
    #1 check("hello_first_ready", req_ready, 4'b0001);
    feed(0, 0, 2);
    wait_dig(0, "hello");

    // Requesters 0 and 2 from reset, then 0 loses to pending 3
    do_reset();
    msg_w[0] = 32'h01020304; msg_w[1] = 32'h05060000; msg_n = 2; msg_bn = 2'd2;
    present(0, msg_w[0], 1'b0, 2'd0);
    present(2, 32'hCAFEBABE, 1'b1, 2'd1);
    await_grant(0);
    feed(0, 0, 1);
    wait_dig(0, "rr_r0");
    msg_w[0] = 32'hCAFEBABE; msg_n = 1; msg_bn = 2'd1;
    await_grant(2);
    feed(2, 0, 0);
    wait_dig(2, "rr_r2");
    present(0, 32'h0000AAAA, 1'b1, 2'd2);
    present(3, 32'h3333CCCC, 1'b1, 2'd1);
    await_grant(3);
    msg_w[0] = 32'h3333CCCC; msg_n = 1; msg_bn = 2'd1;
    feed(3, 0, 0);
    wait_dig(3, "rr_r3");
    msg_w[0] = 32'h0000AAAA; msg_n = 1; msg_bn = 2'd2;
    await_grant(0);
    feed(0, 0, 0);
    wait_dig(0, "rr_r0b");

    // Buffer full holds the word path without losing words
    msg_w[0] = 32'hA1A2A3A4; msg_w[1] = 32'hB1B2B3B4; msg_w[2] = 32'hC1C2C3C4;
    msg_n = 3; msg_bn = 2'd2;
    present(1, msg_w[0], 1'b0, 2'd0);
    await_grant(1);
    feed(1, 0, 0);
    core_buffer_full = 1'b1;
    present(1, msg_w[1], 1'b0, 2'd0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 seen = seen | (|req_ready) | core_in_ready;
      @(negedge clk);
    end
    check("full_no_ready", seen, 0);
    core_buffer_full = 1'b0;
    feed(1, 1, 2);
    wait_dig(1, "full");

    // 16-byte message needs the terminal zero word
    msg_w[0] = 32'h54657374; msg_w[1] = 32'h696E6720; msg_w[2] = 32'h312C2032;
    msg_w[3] = 32'h2C20332E; msg_w[4] = 32'h00000000; msg_n = 5; msg_bn = 2'd0;
    present(0, msg_w[0], 1'b0, 2'd0);
    await_grant(0);
    feed(0, 0, 3);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen = seen | (|dig_valid);
      @(negedge clk);
    end
    check("term_no_early_dig", seen, 0);
    check("term_grant_held", grant, 4'b0001);
    feed(0, 4, 4);
    wait_dig(0, "term");

    // Reset during FEED of requester 1
    msg_w[0] = 32'h11112222; msg_w[1] = 32'h33334444; msg_w[2] = 32'h55556666;
    msg_n = 3; msg_bn = 2'd1;
    present(1, msg_w[0], 1'b0, 2'd0);
    await_grant(1);
    feed(1, 0, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_grant", grant, 0);
    check("midrst_core_reset", core_reset, 1);
    check("midrst_digest", digest, 0);
    check("midrst_dig_valid", dig_valid, 0);
    check("midrst_core_in_ready", core_in_ready, 0);
    check("midrst_abort", abort, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    present(1, msg_w[0], 1'b0, 2'd0);
    await_grant(1);
    feed(1, 0, 2);
    wait_dig(1, "after_rst");

`ifdef KECCAK_ARB_TIMEOUT_EN
    // Stall abort: pointer is 2, so serve 0 first to bring it to 1
    msg_w[0] = 32'h0BADF00D; msg_n = 1; msg_bn = 2'd3;
    present(0, msg_w[0], 1'b1, 2'd3);
    await_grant(0);
    feed(0, 0, 0);
    wait_dig(0, "pre_abort");
    msg_w[0] = 32'h77778888; msg_w[1] = 32'h9999AAAA; msg_w[2] = 32'hBBBBCCCC;
    msg_n = 3; msg_bn = 2'd1;
    present(1, msg_w[0], 1'b0, 2'd0);
    present(2, 32'hDEADBEEF, 1'b1, 2'd2);
    await_grant(1);
    feed(1, 0, 1);
    hit = 0;
    seen = 1'b0;
    for (int c = 1; c <= 8 && hit == 0; c++) begin
      @(negedge clk);
      #1;
      seen = seen | (|dig_valid);
      if (abort != '0) hit = c;
    end
    check("abort_cycle", hit, 4);
    check("abort_vec", abort, 4'b0010);
    check("abort_no_dig", seen, 0);
    @(negedge clk);
    check("abort_pulse_end", abort, 0);
    check("abort_next_grant", grant, 4'b0100);
    @(negedge clk);
    msg_w[0] = 32'hDEADBEEF; msg_n = 1; msg_bn = 2'd2;
    feed(2, 0, 0);
    wait_dig(2, "post_abort");
`else
    // Without the timeout a long stall is harmless and abort stays 0
    msg_w[0] = 32'h12345678; msg_w[1] = 32'h9ABCDEF0; msg_n = 2; msg_bn = 2'd3;
    present(2, msg_w[0], 1'b0, 2'd0);
    await_grant(2);
    feed(2, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seen = seen | (|abort) | (|dig_valid);
      @(negedge clk);
    end
    check("stall_no_abort", seen, 0);
    check("stall_grant_held", grant, 4'b0100);
    feed(2, 1, 1);
    wait_dig(2, "stall");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
